// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC NCO sequencer: data width, binary-angle
// constants, sequencer state encoding and a saturating negate.
package cordic_pkg;

  localparam int unsigned W = 18;

  // Binary angle: 2^W represents 360 degrees.
  localparam logic [W-1:0] ANG_90  = W'(1) << (W - 2);
  localparam logic [W-1:0] ANG_180 = W'(1) << (W - 1);

  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } seq_state_e;

  // Two's complement negate; the most negative value maps to the most positive.
  function automatic logic [W-1:0] sat_neg(input logic [W-1:0] x);
    logic [W-1:0] r;
    if (x == ANG_180) begin
      r = POS_MAX;
    end else begin
      r = ~x + W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/cordic_nco_seq_if.sv
// Start/done handshake and operand/result bus between the sequencer and cordic_top.
interface cordic_nco_seq_if;
  import cordic_pkg::*;

  logic         cordic_start;
  logic [W-1:0] cordic_x0;
  logic [W-1:0] cordic_y0;
  logic [W-1:0] cordic_z0;
  logic         cordic_done;
  logic [W-1:0] cordic_xn;
  logic [W-1:0] cordic_yn;

  modport master (
    output cordic_start, cordic_x0, cordic_y0, cordic_z0,
    input  cordic_done,  cordic_xn, cordic_yn
  );

  modport slave (
    input  cordic_start, cordic_x0, cordic_y0, cordic_z0,
    output cordic_done,  cordic_xn, cordic_yn
  );

endinterface

// File: rtl/cordic_quad_fold.sv
// Folds a full-circle binary angle into the +/-90 degree CORDIC convergence
// range; neg_o flags that the rotated result must be negated.
module cordic_quad_fold
  import cordic_pkg::*;
(
  input  logic [W-1:0] acc_i,
  output logic [W-1:0] z0_o,
  output logic         neg_o
);

  // Quadrants 01 and 10 lie outside +/-90; shifting by 180 brings them back in.
  always_comb begin
    neg_o = acc_i[W-1] ^ acc_i[W-2];
    z0_o  = neg_o ? (acc_i ^ ANG_180) : acc_i;
  end

endmodule

// File: rtl/cordic_nco_seq.sv
// Sample-rate sequencer: advances a phase accumulator every DIV clocks, launches
// one CORDIC rotation per tick and returns a quadrant-corrected cos/sin pair.
module cordic_nco_seq
  import cordic_pkg::*;
#(
  parameter int unsigned DIV     = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [W-1:0]            phase_inc,
  input  logic [W-1:0]            amp,
  cordic_nco_seq_if.master        cordic,
  output logic [W-1:0]            cos_out,
  output logic [W-1:0]            sin_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err
);

  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT - 1);

  seq_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic [W-1:0]      acc_q;
  logic [W-1:0]      acc_d;
  logic [W-1:0]      x0_q;
  logic [W-1:0]      z0_q;
  logic              neg_q;
  logic              start_q;
  logic [W-1:0]      cos_q;
  logic [W-1:0]      sin_q;
  logic              valid_q;
  logic              busy_q;
  logic              overrun_q;
  logic              timeout_q;

  logic              tick_c;
  logic [W-1:0]      fold_z0_c;
  logic              fold_neg_c;

  cordic_quad_fold u_fold (
    .acc_i (acc_q),
    .z0_o  (fold_z0_c),
    .neg_o (fold_neg_c)
  );

  always_comb begin
    tick_c = en && (cnt_q == CNT_MAX);
    cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    acc_d  = acc_q + phase_inc;
  end

  // Divider, accumulator and sequencer FSM; reset wins over any in-flight rotation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      acc_q     <= '0;
      x0_q      <= '0;
      z0_q      <= '0;
      neg_q     <= 1'b0;
      start_q   <= 1'b0;
      cos_q     <= '0;
      sin_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      valid_q <= 1'b0;

      if (en) begin
        cnt_q <= cnt_d;
      end
      // The phase advances on every tick, dropped or not, to keep frequency exact.
      if (tick_c) begin
        acc_q <= acc_d;
      end
      if (tick_c && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (tick_c) begin
            x0_q    <= amp;
            z0_q    <= fold_z0_c;
            neg_q   <= fold_neg_c;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          wcnt_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cordic.cordic_done) begin
            cos_q   <= neg_q ? sat_neg(cordic.cordic_xn) : cordic.cordic_xn;
            sin_q   <= neg_q ? sat_neg(cordic.cordic_yn) : cordic.cordic_yn;
            valid_q <= 1'b1;
            state_q <= CAPTURE;
          end else if (wcnt_q == WCNT_MAX) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        CAPTURE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cordic.cordic_start = start_q;
  assign cordic.cordic_x0    = x0_q;
  assign cordic.cordic_y0    = '0;
  assign cordic.cordic_z0    = z0_q;

  assign cos_out     = cos_q;
  assign sin_out     = sin_q;
  assign out_valid   = valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_cordic_nco_seq.sv
// Scoreboard bench for cordic_nco_seq with a behavioural CORDIC responder:
// expected launches and samples are queued by the stimulus, popped by a monitor.
`timescale 1ns/1ps
module tb_cordic_nco_seq;
  import cordic_pkg::*;

  localparam int unsigned DIV     = 32;
  localparam int unsigned TIMEOUT = 255;
  localparam logic [W-1:0] ANG_M90 = ANG_90 | ANG_180;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic [W-1:0] phase_inc = '0;
  logic [W-1:0] amp = '0;
  logic [W-1:0] cos_out, sin_out;
  logic         out_valid, busy, overrun, timeout_err;

  cordic_nco_seq_if cif ();

  cordic_nco_seq #(.DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .phase_inc   (phase_inc),
    .amp         (amp),
    .cordic      (cif),
    .cos_out     (cos_out),
    .sin_out     (sin_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;

  logic [W-1:0] exp_z0_q[$];
  logic [W-1:0] exp_x0_q[$];
  logic [W-1:0] exp_cos_q[$];
  logic [W-1:0] exp_sin_q[$];

  function automatic logic [W-1:0] s(input int v);
    return W'(v);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic push_launch(input logic [W-1:0] z0, input logic [W-1:0] x0);
    exp_z0_q.push_back(z0);
    exp_x0_q.push_back(x0);
  endtask

  task automatic push_result(input int c, input int sn);
    exp_cos_q.push_back(s(c));
    exp_sin_q.push_back(s(sn));
  endtask

  // Responder: 0 = gain-scaled rotation by 0/+90/-90, 1 = never done, 2 = xn forced to -2^(W-1).
  int           mdl_mode = 0;
  int           mdl_lat  = 20;
  int           cd       = 0;
  logic [W-1:0] m_x0 = '0;
  logic [W-1:0] m_z0 = '0;

  function automatic logic [2*W-1:0] model_xy(input logic [W-1:0] x0, input logic [W-1:0] z0,
                                              input int mode);
    int g;
    logic [W-1:0] xn, yn;
    g  = int'($signed(x0)) * 1647 / 1000;
    xn = '0;
    yn = '0;
    if (mode == 2) begin
      xn = ANG_180;
    end else if (z0 == '0) begin
      xn = W'(g);
    end else if (z0 == ANG_90) begin
      yn = W'(g);
    end else if (z0 == ANG_M90) begin
      yn = W'(-g);
    end
    return {xn, yn};
  endfunction

  always @(posedge clk) begin
    cif.cordic_done <= 1'b0;
    if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        cif.cordic_done <= 1'b1;
        {cif.cordic_xn, cif.cordic_yn} <= model_xy(m_x0, m_z0, mdl_mode);
      end
    end
    if (cif.cordic_start && mdl_mode != 1) begin
      cd   <= mdl_lat;
      m_x0 <= cif.cordic_x0;
      m_z0 <= cif.cordic_z0;
    end
  end

  // Monitor: compares every launch and every output strobe against the queues.
  logic prev_done = 1'b0, prev_valid = 1'b0, prev_start = 1'b0;
  always @(negedge clk) begin
    if (cif.cordic_start) begin
      chk("start_one_cycle", W'(prev_start), '0);
      if (exp_z0_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_launch actual=z0 %0d required=no launch", cif.cordic_z0);
      end else begin
        chk("launch_z0", cif.cordic_z0, exp_z0_q.pop_front());
        chk("launch_x0", cif.cordic_x0, exp_x0_q.pop_front());
        chk("launch_y0", cif.cordic_y0, '0);
      end
    end
    if (out_valid) begin
      valid_cnt++;
      chk("valid_after_done", W'(prev_done), W'(1));
      chk("valid_one_cycle", W'(prev_valid), '0);
      if (exp_cos_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=cos %0d required=no strobe", $signed(cos_out));
      end else begin
        chk("cos_out", cos_out, exp_cos_q.pop_front());
        chk("sin_out", sin_out, exp_sin_q.pop_front());
      end
    end
    prev_start = cif.cordic_start;
    prev_done  = cif.cordic_done;
    prev_valid = out_valid;
  end

  task automatic wait_valids(input int target, input int bound, input string name);
    int n = 0;
    while (valid_cnt < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (valid_cnt < target) begin
      errors++;
      $display("FAIL %s actual=%0d strobes required=%0d", name, valid_cnt, target);
    end
  endtask

  task automatic wait_start(input int bound, input string name);
    int n = 0;
    while (!cif.cordic_start && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cif.cordic_start) begin
      errors++;
      $display("FAIL %s actual=no start required=start within %0d", name, bound);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cos"}, cos_out, '0);
    chk({tag, "_sin"}, sin_out, '0);
    chk({tag, "_valid"}, W'(out_valid), '0);
    chk({tag, "_busy"}, W'(busy), '0);
    chk({tag, "_overrun"}, W'(overrun), '0);
    chk({tag, "_timeout"}, W'(timeout_err), '0);
    chk({tag, "_start"}, W'(cif.cordic_start), '0);
    chk({tag, "_x0"}, cif.cordic_x0, '0);
    chk({tag, "_z0"}, cif.cordic_z0, '0);
  endtask

  initial begin
    int n;
    // Reset and idle with en low
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    repeat (500) @(negedge clk);
    chk_all_zero("idle");

    // Basic launch at phase 0
    amp = s(1000);
    mdl_mode = 0;
    mdl_lat = 20;
    push_launch('0, s(1000));
    push_result(1647, 0);
    en = 1'b1;
    wait_valids(1, 200, "basic_strobe");
    en = 1'b0;

    // Quadrant walk in 90 degree steps
    phase_inc = ANG_90;
    push_launch('0, s(1000));      push_result(1647, 0);
    push_launch(ANG_M90, s(1000)); push_result(0, 1647);
    push_launch('0, s(1000));      push_result(-1647, 0);
    push_launch(ANG_M90, s(1000)); push_result(0, -1647);
    en = 1'b1;
    wait_valids(5, 300, "quadrant_strobes");
    en = 1'b0;
    chk("no_overrun_yet", W'(overrun), '0);

    // Overrun: rotation slower than the tick period; dropped tick still advances phase
    mdl_lat = 40;
    push_launch('0, s(1000)); push_result(1647, 0);
    push_launch('0, s(1000)); push_result(-1647, 0);
    en = 1'b1;
    wait_valids(7, 250, "overrun_strobes");
    en = 1'b0;
    chk("overrun_set", W'(overrun), W'(1));

    // Timeout, then relaunch on the next tick
    phase_inc = '0;
    mdl_mode = 1;
    mdl_lat = 20;
    push_launch('0, s(1000));
    en = 1'b1;
    wait_start(100, "timeout_launch");
    n = 0;
    while (!timeout_err && n <= 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", W'(n), W'(TIMEOUT + 1));
    chk("timeout_idle_busy", W'(busy), '0);
    chk("timeout_no_valid", W'(out_valid), '0);
    mdl_mode = 0;
    push_launch('0, s(1000)); push_result(1647, 0);
    wait_valids(8, 100, "relaunch_strobe");
    en = 1'b0;
    chk("timeout_sticky", W'(timeout_err), W'(1));

    // Reset during WAIT; the late done must be ignored
    push_launch('0, s(1000));
    en = 1'b1;
    wait_start(100, "midrot_launch");
    repeat (5) @(negedge clk);
    chk("midrot_busy", W'(busy), W'(1));
    rst = 1'b0;
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk_all_zero("midrot");

    // Saturating negate of the most negative xn
    amp = s(-5000);
    phase_inc = ANG_90;
    mdl_mode = 2;
    push_launch('0, s(-5000));     push_result(-131072, 0);
    push_launch(ANG_M90, s(-5000)); push_result(131071, 0);
    en = 1'b1;
    wait_valids(10, 200, "sat_strobes");
    en = 1'b0;
    chk("sat_no_overrun", W'(overrun), '0);
    repeat (10) @(negedge clk);

    chk("launch_queue_empty", W'(exp_z0_q.size()), '0);
    chk("result_queue_empty", W'(exp_cos_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_nco_seq.md
Name: cordic_nco_seq

Overview:
- Sample-rate sequencer that sits directly upstream of cordic_top (rotation mode) and also consumes its outputs.
- On each sample tick it:
  - advances a phase accumulator,
  - folds the phase into the CORDIC convergence range (±90°),
  - launches one CORDIC rotation via the start/done handshake,
  - captures xn/yn and applies the quadrant correction.
- Result is a registered cos/sin sample pair with a one-cycle valid strobe, feeding downstream DSP or DAC logic.

Parameters:
- W, 18, data and angle width. Angle is binary: 2^W = 360°, two's complement (e.g. 43690 = 60°).
- DIV, 64, clk cycles per sample tick (≥ 2).
- TIMEOUT, 255, maximum clk cycles to wait for cordic_done before aborting.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- en  in  1  enables the tick divider and accumulator. 0 freezes the phase and issues no new launches.
- phase_inc  in  W  phase increment per tick (binary angle).
- amp  in  W  signed amplitude, driven onto cordic_x0, pre-scaled by the bench/user for CORDIC gain.
- cordic_start  out  1  one-cycle launch pulse to cordic_top.start.
- cordic_x0  out  W  initial x, equals amp sampled at launch.
- cordic_y0  out  W  always 0.
- cordic_z0  out  W  folded angle.
- cordic_done  in  1  completion pulse from cordic_top.
- cordic_xn  in  W  rotated x.
- cordic_yn  in  W  rotated y.
- cos_out  out  W  signed cosine sample.
- sin_out  out  W  signed sine sample.
- out_valid  out  1  one-cycle strobe; cos_out/sin_out are new.
- busy  out  1  high from LAUNCH until return to IDLE.
- overrun  out  1  sticky: a tick arrived while busy.
- timeout_err  out  1  sticky: cordic_done never arrived.

Behaviour:
- Reset (rst=0 at a clk edge):
  - phase accumulator, tick counter, all outputs and both sticky flags go to 0.
  - FSM goes to IDLE.
  - Takes priority over every other event, including mid-rotation. A cordic_done arriving after reset is ignored.
- Tick divider:
  - counts 0..DIV-1 while en=1; tick asserts for one cycle when count = DIV-1.
  - en=0 holds the count.
- Phase accumulator:
  - on every tick, acc <= acc + phase_inc, modulo 2^W.
  - advances even when the tick is dropped, which preserves frequency accuracy.
- Fold, computed from the pre-increment acc at launch:
  - q = acc[W-1:W-2].
  - q = 00 or 11: z0 = acc, neg = 0.
  - q = 01 or 10: z0 = acc with MSB inverted (±180°), neg = 1.
- FSM states:
  - IDLE: tick → LAUNCH. Latch cordic_x0 = amp, cordic_z0 = folded acc, neg flag.
  - LAUNCH: cordic_start = 1 for exactly this cycle; go to WAIT. Clear the wait counter.
  - WAIT:
    - cordic_done = 1 → CAPTURE.
    - wait counter reaching TIMEOUT → IDLE, with timeout_err <= 1 and no out_valid.
    - A cordic_done arriving in the cycle immediately after LAUNCH is accepted.
  - CAPTURE:
    - cos_out = neg ? -xn : xn; sin_out = neg ? -yn : yn.
    - Negation saturates: -(-2^(W-1)) gives 2^(W-1)-1.
    - out_valid = 1 this cycle; go to IDLE.
- Tick in any state other than IDLE: tick dropped, overrun <= 1, accumulator still advances.
- Tick coinciding with the CAPTURE→IDLE transition: counts as an overrun. No back-to-back launch.
- Latency: tick → cordic_start is 1 cycle; cordic_done → out_valid is 1 cycle.
- cos_out/sin_out hold their values between strobes.
- busy = (state ≠ IDLE).
- en deasserted mid-rotation: the current rotation completes normally.
- cordic_x0/z0 are held stable from LAUNCH until return to IDLE.

Decomposition:
- Shared package cordic_pkg holds:
  - W and the angle constants ANG_90 = 2^(W-2) and ANG_180 = 2^(W-1);
  - the FSM state encoding: IDLE, LAUNCH, WAIT, CAPTURE;
  - a saturating negate function.
- One natural sub-module: cordic_quad_fold, the combinational fold of acc to z0 and neg, reusable by the vectoring path.
- Tick divider stays inline.

Test Plan:
- Reset/idle: rst=0 for 3 cycles, then 1, with en=0 → all outputs 0, no cordic_start for 500 cycles.
- Basic launch: en=1, amp=1000, phase_inc=0, behavioural CORDIC model with 20-cycle latency.
  - First tick gives cordic_z0=0, x0=1000, y0=0.
  - out_valid exactly 1 cycle after done, cos_out≈1000×K, sin_out≈0.
- Quadrant fold: phase_inc=65536 (90°).
  - Successive launches give z0 = 0, 196608 (-90°), 0, 196608.
  - neg = 0, 1, 1, 0.
  - Sign of sin_out follows 0°, 90°, 180°, 270°.
- Overrun: DIV=8, model latency 20 → overrun=1 after the second tick.
  - Phase still steps by phase_inc per tick.
  - Launches occur only from IDLE.
- Timeout: model never pulses done → after 255 WAIT cycles timeout_err=1, FSM in IDLE, no out_valid; the next tick relaunches.
- Reset mid-rotation: rst=0 during WAIT, late done injected → no out_valid, all outputs 0, flags cleared.
- Saturation: model returns xn=-131072 with neg=1 → cos_out=131071.
